// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the stage-based game controller.
//   state_e        - controller FSM states
//   MAX_SCORE      - ceiling applied to incoming work scores
//   BONUS_SHIFT    - weight (as a left shift) of the carried bonus and of luck
//   LFSR_*         - width and tap positions of the x^10 + x^7 + 1 LFSR
//   clamp_score    - saturate a raw work value to MAX_SCORE
//   hard_from_low7 - fold the low 7 LFSR bits into the 0..MAX_SCORE range
package game_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWaitWork,
      StEval,
      StDone
   } state_e;

   localparam int unsigned MAX_SCORE   = 100;
   localparam int unsigned BONUS_SHIFT = 2;

   localparam int unsigned LFSR_WIDTH = 10;
   localparam int unsigned LFSR_TAP_A = 9;   // x^10 term
   localparam int unsigned LFSR_TAP_B = 6;   // x^7 term

   function automatic logic [6:0] clamp_score(logic [6:0] raw);
      return (raw > 7'(MAX_SCORE)) ? 7'(MAX_SCORE) : raw;
   endfunction

   // Values above MAX_SCORE are pulled down by (127 - MAX_SCORE) so the
   // largest 7-bit value lands exactly on MAX_SCORE.
   function automatic logic [6:0] hard_from_low7(logic [6:0] low7);
      return (low7 > 7'(MAX_SCORE)) ? (low7 - 7'(127 - MAX_SCORE)) : low7;
   endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: valid/ready handshake carrying one stage work score.
//   work_valid - producer offers a work score
//   work       - 7-bit work score (clamped by the consumer)
//   work_ready - consumer can take a score this cycle
// Modports: master = score producer, slave = game controller.
interface game_ctrl_if;

   logic       work_valid;
   logic [6:0] work;
   logic       work_ready;

   modport master (
      output work_valid,
      output work,
      input  work_ready
   );

   modport slave (
      input  work_valid,
      input  work,
      output work_ready
   );

endinterface

// File: rtl/game_lfsr.sv
// game_lfsr: 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1.
//   clk  - clock
//   rst  - synchronous active-high reset, loads SEED
//   adv  - shift by one position this cycle; otherwise hold
//   lfsr - current register contents
// SEED must be nonzero or the register locks up at zero.
module game_lfsr
   import game_pkg::*;
#(
   parameter logic [LFSR_WIDTH-1:0] SEED = 10'h2A5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  adv,
   output logic [LFSR_WIDTH-1:0] lfsr
);

   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (adv) begin
         lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: multi-stage game controller.
// A game runs up to NUM_STAGES stages. Each stage takes one work score over
// work_if, adds the carried bonus and a luck term (both weighted by
// 2^BONUS_SHIFT) and passes when that total beats a per-stage difficulty.
// Difficulty and luck come from an LFSR that advances once per evaluation.
//   clk         - clock
//   rst         - synchronous active-high reset
//   start       - begin a game (only honoured while idle)
//   work_if     - slave side of the work score handshake
//   busy        - game in progress (any state but idle)
//   stage_idx   - stage currently being played
//   done        - one-cycle pulse at the end of a game
//   win         - every stage passed; held until the next start
//   fail_stage  - stage that failed (0 on a win)
//   final_bonus - bonus carried out of the last evaluated stage
// Build option GAME_CTRL_HARD_OVERRIDE_EN: adds hard_ovr/luck_ovr inputs that
// replace the LFSR-derived difficulty and luck; no LFSR is built in that case.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned           NUM_STAGES = 4,
   parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 10'h2A5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   game_ctrl_if.slave work_if,
`ifdef GAME_CTRL_HARD_OVERRIDE_EN
   input  logic [6:0] hard_ovr,
   input  logic [1:0] luck_ovr,
`endif
   output logic       busy,
   output logic [1:0] stage_idx,
   output logic       done,
   output logic       win,
   output logic [1:0] fail_stage,
   output logic [1:0] final_bonus
);

   localparam logic [1:0] LastStage = 2'(NUM_STAGES - 1);

   state_e     state_q, state_d;
   logic [1:0] stage_q, stage_d;
   logic [1:0] bonus_q, bonus_d;
   logic [6:0] work_q, work_d;
   logic       win_q, win_d;
   logic [1:0] fail_q, fail_d;
   logic [1:0] fbonus_q, fbonus_d;

   logic [6:0] hard;
   logic [1:0] luck;
   logic [6:0] total;
   logic       pass;

   // ---------------------------------------------------------------------
   // Difficulty / luck source
   // ---------------------------------------------------------------------
`ifdef GAME_CTRL_HARD_OVERRIDE_EN
   assign hard = hard_ovr;
   assign luck = luck_ovr;
`else
   logic [LFSR_WIDTH-1:0] lfsr_state;
   logic                  lfsr_adv;
   logic                  unused_lfsr_bit;

   // One step per evaluation, so each stage sees a fresh draw.
   assign lfsr_adv = (state_q == StEval);

   game_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .adv  (lfsr_adv),
      .lfsr (lfsr_state)
   );

   assign hard            = hard_from_low7(lfsr_state[6:0]);
   assign luck            = lfsr_state[9:8];
   assign unused_lfsr_bit = lfsr_state[7];
`endif

   // ---------------------------------------------------------------------
   // Stage scoring: work <= 100 and both weighted terms <= 12, so the sum
   // never exceeds 124 and fits in 7 bits.
   // ---------------------------------------------------------------------
   assign total = work_q + (7'(bonus_q) << BONUS_SHIFT) + (7'(luck) << BONUS_SHIFT);
   assign pass  = (total > hard);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      bonus_d  = bonus_q;
      work_d   = work_q;
      win_d    = win_q;
      fail_d   = fail_q;
      fbonus_d = fbonus_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StWaitWork;
               stage_d  = '0;
               bonus_d  = '0;
               win_d    = 1'b0;
               fail_d   = '0;
               fbonus_d = '0;
            end
         end

         StWaitWork: begin
            // work_ready is high throughout this state, so valid alone
            // completes the handshake.
            if (work_if.work_valid) begin
               work_d  = clamp_score(work_if.work);
               state_d = StEval;
            end
         end

         StEval: begin
            if (pass) begin
               bonus_d = total[6:5];
               if (stage_q == LastStage) begin
                  win_d    = 1'b1;
                  fail_d   = '0;
                  fbonus_d = total[6:5];
                  state_d  = StDone;
               end else begin
                  stage_d = stage_q + 2'd1;
                  state_d = StWaitWork;
               end
            end else begin
               bonus_d  = '0;
               fail_d   = stage_q;
               win_d    = 1'b0;
               fbonus_d = '0;
               state_d  = StDone;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         stage_q  <= '0;
         bonus_q  <= '0;
         work_q   <= '0;
         win_q    <= 1'b0;
         fail_q   <= '0;
         fbonus_q <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         bonus_q  <= bonus_d;
         work_q   <= work_d;
         win_q    <= win_d;
         fail_q   <= fail_d;
         fbonus_q <= fbonus_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign work_if.work_ready = (state_q == StWaitWork);
   assign busy               = (state_q != StIdle);
   assign done               = (state_q == StDone);
   assign stage_idx          = stage_q;
   assign win                = win_q;
   assign fail_stage         = fail_q;
   assign final_bonus        = fbonus_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of stages per game; legal range 1..4.
REQ-002 Parameter LFSR_SEED, default 10'h2A5, nonzero LFSR reset value.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begins a game; sampled only in IDLE.
REQ-006 work_valid  in  1  stage work value offered.
REQ-007 work  in  7  stage work score, 0..100; values >100 are clamped to 100.
REQ-008 work_ready  out  1  high only in WAIT_WORK.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 stage_idx  out  2  stage currently being played, 0-based.
REQ-011 done  out  1  one-cycle pulse when a game ends.
REQ-012 win  out  1  all NUM_STAGES stages passed; valid from done until next start.
REQ-013 fail_stage  out  2  index of the failing stage; 0 when win=1.
REQ-014 final_bonus  out  2  bonus carried out of the last evaluated stage.

Function
REQ-015 FSM states: IDLE, WAIT_WORK, EVAL, DONE.
REQ-016 IDLE -> WAIT_WORK on start; clears stage_idx, the carried bonus, win and fail_stage.
REQ-017 WAIT_WORK: work is captured when work_valid and work_ready are both high; next state is EVAL; otherwise remain in WAIT_WORK.
REQ-018 EVAL (one cycle): total = work_c + 4*bonus_carry + 4*luck, 7-bit unsigned; max 124, so no overflow.
REQ-019 Pass when total > hard; new bonus_carry = total[6:5].
REQ-020 On fail: bonus_carry cleared, fail_stage = stage_idx, win = 0, next state DONE.
REQ-021 On pass with stage_idx = NUM_STAGES-1: win = 1, next state DONE; otherwise stage_idx increments and next state is WAIT_WORK.
REQ-022 hard = L[6:0] when that value is ≤100, else L[6:0]-27, so hard lies in 0..100; luck = L[9:8]; L is the LFSR state.
REQ-023 LFSR: 10-bit Fibonacci, x^10+x^7+1; advances exactly once, at the end of each EVAL cycle; holds otherwise.
REQ-024 DONE: done = 1 for exactly one cycle, then IDLE; final_bonus = bonus_carry.
REQ-025 start while busy is ignored; start held high in IDLE immediately after DONE begins a new game.
REQ-026 Latency: work handshake to done for a failing stage = 2 cycles; minimum full-game duration = 2*NUM_STAGES+1 cycles from start.

Reset
REQ-027 On rst (including mid-game), the next state is IDLE and all outputs are 0.
REQ-028 On rst, the LFSR is loaded with LFSR_SEED and bonus_carry is cleared.

Configuration
REQ-029 Macro GAME_CTRL_HARD_OVERRIDE_EN defined: adds inputs hard_ovr[6:0] and luck_ovr[1:0], which replace the LFSR-derived hard and luck; the LFSR is not instantiated.
REQ-030 Macro GAME_CTRL_HARD_OVERRIDE_EN undefined: no extra ports; hard and luck are taken from the LFSR per REQ-022.

Structure
REQ-031 Shared package game_pkg holds the FSM state enum, MAX_SCORE = 100, BONUS_SHIFT = 2 and the LFSR tap constants.
REQ-032 Sub-module game_lfsr (10-bit, advance enable, seed parameter) is instantiated once; stage scoring is inline.

Verification
REQ-033 Default seed; start; work=30 -> stage 0: hard=37, luck=2, total=38, pass, bonus_carry=1, stage_idx=1.
REQ-034 Override enabled: hard_ovr=100, luck_ovr=3, work=100 on all 4 stages -> done after 9 cycles, win=1, final_bonus=3.
REQ-035 Override enabled: hard_ovr=100, luck_ovr=0, work=100 at stage 0 -> total=100, fail, fail_stage=0, win=0, done 2 cycles after handshake.
REQ-036 work=127 with override hard=99, luck=0 -> work clamped to 100, pass, bonus=3.
REQ-037 rst asserted in WAIT_WORK at stage 2 -> next cycle IDLE, busy=0, stage_idx=0, LFSR=10'h2A5.
REQ-038 start pulsed during WAIT_WORK; work_valid held low 5 cycles -> state unchanged, work_ready held high, stage_idx unchanged.
